// File: rtl/hmcs_timer_intc_if.sv
// Command and interrupt handshake between the core decoder (master) and hmcs_timer_intc (slave).
interface hmcs_timer_intc_if #(
  parameter int unsigned NCH   = 2,
  parameter int unsigned CNT_W = 4
);
  localparam int unsigned ARG_W = (CNT_W > 3) ? CNT_W : 3;
  localparam int unsigned VW    = $clog2(NCH + 1);

  logic             i_cmd_valid;
  logic [3:0]       i_cmd;
  logic [ARG_W-1:0] i_cmd_arg;
  logic             i_irq_ack;
  logic             o_irq;
  logic [VW-1:0]    o_vector;

  modport master (output i_cmd_valid, i_cmd, i_cmd_arg, i_irq_ack,
                  input  o_irq, o_vector);
  modport slave  (input  i_cmd_valid, i_cmd, i_cmd_arg, i_irq_ack,
                  output o_irq, o_vector);
endinterface

// File: rtl/hmcs_timer_intc.sv
// HMCS4x timer/counter and N-channel interrupt controller with edge-latched pending requests.
// Optional HMCS_TIMER_RELOAD_EN adds a RELOAD register (command A) used as the overflow wrap value.
module hmcs_timer_intc #(
  parameter int unsigned NCH     = 2,
  parameter int unsigned PRE_W   = 6,
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned CNT_SRC = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ce,
  input  logic [NCH-1:0]      i_int,
  hmcs_timer_intc_if.slave    bus,
  output logic [CNT_W-1:0]    o_counter,
  output logic                o_ie,
  output logic [NCH:0]        o_flags
);

  localparam int unsigned ARG_W = (CNT_W > 3) ? CNT_W : 3;
  localparam int unsigned VW    = $clog2(NCH + 1);

  localparam logic [3:0] CMD_SEIE = 4'h0;
  localparam logic [3:0] CMD_REIE = 4'h1;
  localparam logic [3:0] CMD_SETF = 4'h2;
  localparam logic [3:0] CMD_RETF = 4'h3;
  localparam logic [3:0] CMD_SEIF = 4'h4;
  localparam logic [3:0] CMD_REIF = 4'h5;
  localparam logic [3:0] CMD_SECF = 4'h6;
  localparam logic [3:0] CMD_RECF = 4'h7;
  localparam logic [3:0] CMD_LT   = 4'h8;
  localparam logic [3:0] CMD_RTNI = 4'h9;
  localparam logic [3:0] CMD_LRL  = 4'hA;

  logic [NCH-1:0]   sync1_q, sync2_q;
  logic [NCH-1:0]   prev_q, prev_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NCH:0]     pend_q, pend_d;
  logic [NCH:0]     flags_q, flags_d;
  logic             ir_q, ir_d;
  logic             ie_q, ie_d;
  logic             irq_q, irq_d;
  logic             cf_q, cf_d;
  logic [VW-1:0]    vec_q, vec_d;
  logic [CNT_W-1:0] wrap_val;

`ifdef HMCS_TIMER_RELOAD_EN
  logic [CNT_W-1:0] reload_q, reload_d;
  assign wrap_val = reload_q;
`else
  assign wrap_val = '0;
`endif

  logic [NCH-1:0] edge_c;
  logic [NCH-1:0] chan_hit;
  logic [NCH:0]   req_c;
  logic           win_found;
  logic [VW-1:0]  win_idx;
  logic           po_c;
  logic           cnt_pulse;
  logic           cmd_lt;

  // Two-flop synchroniser on the raw interrupt lines, free-running on clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= i_int;
      sync2_q <= sync1_q;
    end
  end

  assign edge_c    = sync2_q & ~prev_q;
  assign po_c      = &pre_q;
  assign cnt_pulse = cf_q ? edge_c[CNT_SRC] : po_c;
  assign cmd_lt    = bus.i_cmd_valid && (bus.i_cmd == CMD_LT);
  assign req_c     = pend_q & ~flags_q;

  // Channel-select decode of the command argument; out-of-range indices hit nothing.
  always_comb begin
    chan_hit = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      chan_hit[i] = (bus.i_cmd_arg == ARG_W'(i));
    end
  end

  // Fixed priority: lowest index wins, timer (index NCH) lowest.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = int'(NCH); i >= 0; i--) begin
      if (req_c[i]) begin
        win_found = 1'b1;
        win_idx   = VW'(i);
      end
    end
  end

  // Next-state logic; everything except the synchroniser advances only on ce.
  always_comb begin
    prev_d  = prev_q;
    pre_d   = pre_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    flags_d = flags_q;
    ir_d    = ir_q;
    ie_d    = ie_q;
    cf_d    = cf_q;
    vec_d   = vec_q;
`ifdef HMCS_TIMER_RELOAD_EN
    reload_d = reload_q;
`endif
    if (ce) begin
      prev_d = sync2_q;
      pre_d  = pre_q + PRE_W'(1);

      if (cnt_pulse && !cmd_lt) begin
        if (&cnt_q) begin
          cnt_d = wrap_val;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      if (bus.i_cmd_valid) begin
        case (bus.i_cmd)
          CMD_SEIE: ie_d = 1'b1;
          CMD_REIE: ie_d = 1'b0;
          CMD_SETF: flags_d[NCH] = 1'b1;
          CMD_RETF: flags_d[NCH] = 1'b0;
          CMD_SEIF: flags_d[NCH-1:0] = flags_d[NCH-1:0] | chan_hit;
          CMD_REIF: flags_d[NCH-1:0] = flags_d[NCH-1:0] & ~chan_hit;
          CMD_SECF: cf_d = 1'b1;
          CMD_RECF: cf_d = 1'b0;
          CMD_LT: begin
            cnt_d = CNT_W'(bus.i_cmd_arg);
            pre_d = '0;
          end
          CMD_RTNI: ie_d = 1'b1;
`ifdef HMCS_TIMER_RELOAD_EN
          CMD_LRL: reload_d = CNT_W'(bus.i_cmd_arg);
`endif
          default: ;
        endcase
      end

      // Arbitration after commands so the winner's flag is set even against a same-ce REIF.
      if (!ir_q && win_found) begin
        ir_d             = 1'b1;
        flags_d[win_idx] = 1'b1;
        pend_d[win_idx]  = 1'b0;
        vec_d            = win_idx;
      end

      // New events are latched after the winner clears, so a fresh edge is never lost.
      pend_d[NCH-1:0] = pend_d[NCH-1:0] | edge_c;
      if (cnt_pulse && !cmd_lt && (&cnt_q)) begin
        pend_d[NCH] = 1'b1;
      end

      if (bus.i_irq_ack && irq_q) begin
        ir_d = 1'b0;
        ie_d = 1'b0;
      end
    end
    irq_d = ir_d & ie_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q   <= '0;
      pre_q    <= '0;
      cnt_q    <= '0;
      pend_q   <= '0;
      flags_q  <= '1;
      ir_q     <= 1'b0;
      ie_q     <= 1'b0;
      irq_q    <= 1'b0;
      cf_q     <= 1'b0;
      vec_q    <= '0;
`ifdef HMCS_TIMER_RELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      prev_q   <= prev_d;
      pre_q    <= pre_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      flags_q  <= flags_d;
      ir_q     <= ir_d;
      ie_q     <= ie_d;
      irq_q    <= irq_d;
      cf_q     <= cf_d;
      vec_q    <= vec_d;
`ifdef HMCS_TIMER_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  assign bus.o_irq    = irq_q;
  assign bus.o_vector = vec_q;
  assign o_counter    = cnt_q;
  assign o_ie         = ie_q;
  assign o_flags      = flags_q;

endmodule
